// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus issue controller in front of the UART transmitter.
// Producers push bytes at any rate; the feeder hands one byte at a time to the
// transmitter and waits for its done pulse before handing over the next one.
// A write into a full FIFO is dropped and recorded in a sticky overflow flag.
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_dv,
  input  logic [7:0]        i_wr_byte,
  input  logic              i_clr_ovf,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic              o_tx_dv,
  output logic [7:0]        o_tx_byte,
  input  logic              i_tx_active,
  input  logic              i_tx_done
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_next_s;
  logic              full_s;
  logic              wr_ok_s;
  logic              drop_s;
  logic              pop_s;
  logic              unused_tx_active_s;

  // Transmitter activity is informational only; it never gates the handshake.
  assign unused_tx_active_s = i_tx_active;

  // Accept/drop/pop decisions and next occupancy, all from the registered count.
  always_comb begin
    full_s       = (count_r == CNT_DEPTH);
    wr_ok_s      = i_wr_dv && !full_s;
    drop_s       = i_wr_dv && full_s;
    pop_s        = (state_r == ST_IDLE) && (count_r != CNT_ZERO);
    count_next_s = count_r;
    if (wr_ok_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (!wr_ok_s && pop_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Storage array; no reset because stale entries are never read past count.
  always_ff @(posedge i_clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= i_wr_byte;
    end
  end

  // Pointers, occupancy, registered flags and the sticky overflow bit.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      o_count    <= CNT_ZERO;
      o_full     <= 1'b0;
      o_empty    <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_next_s;
      o_count <= count_next_s;
      o_full  <= (count_next_s == CNT_DEPTH);
      o_empty <= (count_next_s == CNT_ZERO);
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop_s) begin
        o_overflow <= 1'b1;
      end else if (i_clr_ovf) begin
        o_overflow <= 1'b0;
      end
    end
  end

  // Issue FSM: one strobe per byte, then hold off until the transmitter is done.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r   <= ST_IDLE;
      o_tx_dv   <= 1'b0;
      o_tx_byte <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            o_tx_dv   <= 1'b1;
            o_tx_byte <= mem_r[rd_ptr_r];
            state_r   <= ST_ISSUE;
          end else begin
            o_tx_dv <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // A done pulse here belongs to no byte of ours and is ignored.
          o_tx_dv <= 1'b0;
          state_r <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          o_tx_dv <= 1'b0;
          if (i_tx_done) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          o_tx_dv <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
